cache_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of the single-ported cache_2way.
- Lets two requesters share one cache. Port 0 is intended for instruction fetch and port 1 for load/store.
- Each requester uses a req/ack handshake. The arbiter drives the cache data/addr/wr inputs from registers and captures q after a fixed read latency.
- Only one access is outstanding at a time.

---
 rtl/cache_arbiter.sv | 102 ++++++++++
 tb/tb_cache_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin req/ack sequencer sharing one cache between two ports (req/wr/addr/data/ack/rdata x2 in; c_addr/c_data/c_wr/c_q to cache; busy out)
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] c_data,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_wr,
  input  logic [DATA_W-1:0] c_q,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
  state_t r_state, w_state;
  logic r_sel, w_sel, r_ptr, w_ptr, w_pick, w_wr, w_ack0, w_ack1;
  logic [2:0] r_cnt, w_cnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data, w_rd0, w_rd1;
  assign w_pick = req1 & (~req0 | ~r_ptr);
  always_comb begin
    w_state = r_state;
    w_sel = r_sel;
    w_ptr = r_ptr;
    w_cnt = r_cnt;
    w_addr = c_addr;
    w_data = c_data;
    w_wr = 1'b0;
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    w_rd0 = rdata0;
    w_rd1 = rdata1;
    case (r_state)
      IDLE: if (req0 | req1) begin
        w_state = ACCESS;
        w_sel = w_pick;
        w_ptr = w_pick;
        w_addr = w_pick ? addr1 : addr0;
        w_data = w_pick ? data1 : data0;
        w_wr = w_pick ? wr1 : wr0;
      end
      ACCESS: begin
        w_state = c_wr ? ACK : WAIT;
        w_ack0 = c_wr & ~r_sel;
        w_ack1 = c_wr & r_sel;
        w_cnt = 3'd0;
      end
      WAIT: if (r_cnt == 3'(RD_LAT - 1)) begin
        w_state = ACK;
        w_ack0 = ~r_sel;
        w_ack1 = r_sel;
        w_rd0 = r_sel ? rdata0 : c_q;
        w_rd1 = r_sel ? c_q : rdata1;
      end else begin
        w_cnt = r_cnt + 3'd1;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel <= 1'b0;
      r_ptr <= 1'b1;
      r_cnt <= 3'd0;
      c_addr <= '0;
      c_data <= '0;
      c_wr <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      busy <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel <= w_sel;
      r_ptr <= w_ptr;
      r_cnt <= w_cnt;
      c_addr <= w_addr;
      c_data <= w_data;
      c_wr <= w_wr;
      ack0 <= w_ack0;
      ack1 <= w_ack1;
      rdata0 <= w_rd0;
      rdata1 <= w_rd1;
      busy <= w_state != IDLE;
    end
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: randomized and directed checks of cache_arbiter against a transaction-timing reference model
module tb_cache_arbiter;
  localparam int RD_LAT = 3;
  typedef struct {logic wr; logic [31:0] addr; logic [31:0] data;} txn_t;
  logic clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
  logic [1:0] req = 2'b00, wr = 2'b00, ack;
  logic [31:0] addr [2], data [2], rdata [2];
  logic [31:0] c_data, c_addr, c_q;
  logic c_wr, busy;
  logic [31:0] cm [32], pipe [RD_LAT];
  logic [31:0] mm [32], e_rd [2];
  logic [31:0] m_val, e_addr, e_data;
  bit m_act, m_port, m_wr, m_ptr, log_en;
  int m_gt, m_at, m_idle, cyc, n_chk, n_fail;
  int last_ack [2];
  int lp[$], lt[$];
  txn_t q0[$], q1[$];
  always #5 clk = ~clk;
  cache_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .wr0(wr[0]), .addr0(addr[0]), .data0(data[0]), .ack0(ack[0]), .rdata0(rdata[0]),
    .req1(req[1]), .wr1(wr[1]), .addr1(addr[1]), .data1(data[1]), .ack1(ack[1]), .rdata1(rdata[1]),
    .c_data(c_data), .c_addr(c_addr), .c_wr(c_wr), .c_q(c_q), .busy(busy)
  );
  function automatic logic [31:0] init_val(int i);
    return i == 16 ? 32'hDEADBEEF : 32'h01010101 * 32'(i) + 32'h7;
  endfunction
  assign c_q = pipe[RD_LAT-1];
  always @(posedge clk) begin
    pipe[0] <= cm[c_addr[4:0]];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (mem_init) for (int i = 0; i < 32; i++) cm[i] <= init_val(i);
    else if (c_wr) cm[c_addr[4:0]] <= c_data;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  function automatic txn_t rand_txn();
    txn_t t;
    t.wr = 1'($urandom_range(1));
    t.addr = $urandom;
    t.data = $urandom;
    return t;
  endfunction
  task automatic step();
    logic [1:0] e_ack;
    bit p;
    txn_t t;
    e_ack[0] = m_act && cyc == m_at && !m_port;
    e_ack[1] = m_act && cyc == m_at && m_port;
    if (m_act && cyc == m_at && !m_wr) e_rd[m_port] = m_val;
    chk("ack0", 32'(ack[0]), 32'(e_ack[0]));
    chk("ack1", 32'(ack[1]), 32'(e_ack[1]));
    chk("busy", 32'(busy), 32'(m_act && cyc > m_gt && cyc <= m_at));
    chk("c_wr", 32'(c_wr), 32'(m_act && m_wr && cyc == m_gt + 1));
    chk("c_addr", c_addr, e_addr);
    chk("c_data", c_data, e_data);
    chk("rdata0", rdata[0], e_rd[0]);
    chk("rdata1", rdata[1], e_rd[1]);
    for (int i = 0; i < 2; i++) if (ack[i] === 1'b1) begin
      last_ack[i] = cyc;
      if (log_en) begin
        lp.push_back(i);
        lt.push_back(cyc);
      end
    end
    if (req[0] && ack[0] === 1'b1) req[0] = 1'b0;
    if (req[1] && ack[1] === 1'b1) req[1] = 1'b0;
    if (!req[0] && q0.size() > 0) begin
      t = q0.pop_front();
      req[0] = 1'b1; wr[0] = t.wr; addr[0] = t.addr; data[0] = t.data;
    end
    if (!req[1] && q1.size() > 0) begin
      t = q1.pop_front();
      req[1] = 1'b1; wr[1] = t.wr; addr[1] = t.addr; data[1] = t.data;
    end
    if (rst) begin
      m_act = 1'b0; m_ptr = 1'b1; m_idle = cyc + 1;
      e_addr = '0; e_data = '0; e_rd[0] = '0; e_rd[1] = '0;
    end else if (cyc >= m_idle && req != 2'b00) begin
      p = req == 2'b11 ? !m_ptr : req[1];
      m_ptr = p; m_act = 1'b1; m_port = p; m_gt = cyc; m_wr = wr[p];
      e_addr = addr[p]; e_data = data[p];
      m_at = cyc + (m_wr ? 2 : 2 + RD_LAT);
      m_idle = m_at + 1;
      if (m_wr) mm[addr[p][4:0]] = data[p];
      else m_val = mm[addr[p][4:0]];
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req != 2'b00 || busy !== 1'b0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(n), 32'd0);
  endtask
  initial begin
    int c0, la0, la1;
    for (int i = 0; i < 32; i++) mm[i] = init_val(i);
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; data[i] = '0; e_rd[i] = '0; last_ack[i] = -1;
    end
    e_addr = '0; e_data = '0; m_ptr = 1'b1;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b1, 32'h100 + 32'(i), 32'hA0 + 32'(i)});
      q1.push_back('{1'b1, 32'h208 + 32'(i), 32'hB0 + 32'(i)});
    end
    step();
    step();
    rst = 1'b0;
    log_en = 1'b1;
    repeat (40) step();
    log_en = 1'b0;
    chk("grant_count", 32'(lp.size()), 32'd8);
    for (int i = 0; i < lp.size(); i++) begin
      chk("grant_order", 32'(lp[i]), 32'(i % 2));
      if (i > 0) chk("grant_period", 32'(lt[i] - lt[i-1]), 32'd3);
    end
    c0 = cyc;
    q0.push_back('{1'b1, 32'h0, 32'h1});
    drain();
    chk("wr_lat", 32'(last_ack[0] - c0), 32'd2);
    c0 = cyc;
    q0.push_back('{1'b0, 32'h0, 32'h0});
    drain();
    chk("rd_lat0", 32'(last_ack[0] - c0), 32'(2 + RD_LAT));
    chk("rd_val0", rdata[0], 32'h1);
    c0 = cyc;
    q1.push_back('{1'b0, 32'h10, 32'h0});
    drain();
    chk("rd_lat1", 32'(last_ack[1] - c0), 32'(2 + RD_LAT));
    chk("rd_val1", rdata[1], 32'hDEADBEEF);
    chk("rd0_kept", rdata[0], 32'h1);
    la0 = last_ack[0];
    la1 = last_ack[1];
    q0.push_back('{1'b0, 32'h5, 32'h0});
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("abort_ack0", 32'(last_ack[0]), 32'(la0));
    chk("abort_ack1", 32'(last_ack[1]), 32'(la1));
    drain();
    chk("reread_val", rdata[0], init_val(5));
    lp.delete();
    lt.delete();
    q0.push_back('{1'b0, 32'h3, 32'h0});
    repeat (3) step();
    q1.push_back('{1'b0, 32'h7, 32'h0});
    log_en = 1'b1;
    drain();
    log_en = 1'b0;
    chk("arrival_count", 32'(lp.size()), 32'd2);
    if (lp.size() == 2) begin
      chk("arrival_first", 32'(lp[0]), 32'd0);
      chk("arrival_second", 32'(lp[1]), 32'd1);
      chk("arrival_gap", 32'(lt[1] - lt[0]), 32'(3 + RD_LAT));
    end
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(299) == 0;
      if (q0.size() < 2 && $urandom_range(3) == 0) q0.push_back(rand_txn());
      if (q1.size() < 2 && $urandom_range(3) == 0) q1.push_back(rand_txn());
      step();
    end
    rst = 1'b0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
